// File: rtl/l2_dbg_rptr_arb.sv
// l2_dbg_rptr_arb: L2 debug-bus repeater/arbiter.
// Merges NCH source debug buses (data + valid in MSB) onto one pipelined,
// registered debug output with fixed-priority or round-robin selection and
// a trigger/post-count freeze that holds the last captured sample.
//
// Ports:
//   rclk, rst       clock, asynchronous active-high reset
//   dbgbus_in       NCH packed channels of {valid, data[W-1:0]}
//   mode_rr         0 = fixed priority (lowest index), 1 = round robin
//   trig            trigger strobe
//   post_cnt        samples admitted after the trigger sample
//   rearm           return to ARMED and resume capture
//   l2_dbgbus_out   selected data (last pipeline stage)
//   enable_out      selected sample valid
//   src_id          index of the granted channel
//   frozen          capture stopped
module l2_dbg_rptr_arb #(
  parameter int unsigned W      = 40,
  parameter int unsigned NCH    = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned POST_W = 8,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                   rclk,
  input  logic                   rst,
  input  logic [NCH*(W+1)-1:0]   dbgbus_in,
  input  logic                   mode_rr,
  input  logic                   trig,
  input  logic [POST_W-1:0]      post_cnt,
  input  logic                   rearm,
  output logic [W-1:0]           l2_dbgbus_out,
  output logic                   enable_out,
  output logic [SEL_W-1:0]       src_id,
  output logic                   frozen
);

  // Pipeline word layout: {valid, src_id, data}
  localparam int unsigned PW = 1 + SEL_W + W;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [POST_W-1:0]   cnt_q, cnt_d;
  logic                admit_c;
  logic [SEL_W-1:0]    ptr_q;

  logic [W:0]          ch_c [NCH];
  logic [NCH-1:0]      ch_valid_c;
  logic [SEL_W-1:0]    grant_c;
  logic                hit_c;
  logic [W-1:0]        sel_data_c;
  logic [PW-1:0]       stage0_d;
  logic [PW-1:0]       pipe_q [STAGES];

  // Unpack channel fields
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_c[i]       = dbgbus_in[i*(W+1) +: (W+1)];
      ch_valid_c[i] = ch_c[i][W];
    end
  end

  // Arbiter: lowest valid index, or first valid at/after ptr with wrap
  always_comb begin : arb
    int unsigned idx;
    grant_c = '0;
    hit_c   = 1'b0;
    idx     = 0;
    if (mode_rr) begin
      for (int unsigned off = 0; off < NCH; off++) begin
        idx = 32'(ptr_q) + off;
        if (idx >= NCH) idx = idx - NCH;
        if (!hit_c && ch_valid_c[SEL_W'(idx)]) begin
          hit_c   = 1'b1;
          grant_c = SEL_W'(idx);
        end
      end
    end else begin
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
        if (ch_valid_c[SEL_W'(i)]) begin
          hit_c   = 1'b1;
          grant_c = SEL_W'(i);
        end
      end
    end
  end

  assign sel_data_c = hit_c ? ch_c[grant_c][W-1:0] : '0;

  // Frozen stage 0 recirculates so the held sample drains to the pins
  assign stage0_d = admit_c ? {hit_c, grant_c, sel_data_c} : pipe_q[0];

  // Capture FSM next-state; rearm overrides trig and any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    admit_c = 1'b1;
    if (rearm) begin
      state_d = ARMED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (trig) begin
            cnt_d   = post_cnt;
            state_d = (post_cnt == '0) ? FROZEN : POST;
          end
        end
        POST: begin
          cnt_d = cnt_q - POST_W'(1);
          if (cnt_q <= POST_W'(1)) begin
            cnt_d   = '0;
            state_d = FROZEN;
          end
        end
        FROZEN: begin
          admit_c = 1'b0;
        end
        default: begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state, counter, registered frozen flag
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      frozen  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frozen  <= (state_d == FROZEN);
    end
  end

  // Round-robin pointer advances past each admitted grant
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (admit_c && mode_rr && hit_c) begin
      if (grant_c == SEL_W'(NCH - 1)) ptr_q <= '0;
      else                            ptr_q <= grant_c + SEL_W'(1);
    end
  end

  // Output pipeline
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= stage0_d;
      for (int unsigned k = 1; k < STAGES; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign l2_dbgbus_out = pipe_q[STAGES-1][W-1:0];
  assign src_id        = pipe_q[STAGES-1][W +: SEL_W];
  assign enable_out    = pipe_q[STAGES-1][PW-1];

endmodule

// File: tb/tb_l2_dbg_rptr_arb.sv
// Directed testbench for l2_dbg_rptr_arb (NCH=4, STAGES=2, W=40).
module tb_l2_dbg_rptr_arb;

  localparam int unsigned W      = 40;
  localparam int unsigned NCH    = 4;
  localparam int unsigned STAGES = 2;
  localparam int unsigned POST_W = 8;
  localparam int unsigned SEL_W  = 2;

  logic                  rclk;
  logic                  rst;
  logic [NCH*(W+1)-1:0]  dbgbus_in;
  logic                  mode_rr;
  logic                  trig;
  logic [POST_W-1:0]     post_cnt;
  logic                  rearm;
  logic [W-1:0]          l2_dbgbus_out;
  logic                  enable_out;
  logic [SEL_W-1:0]      src_id;
  logic                  frozen;

  logic [W-1:0]          ch_d [NCH];
  logic [NCH-1:0]        ch_v;

  int n_vec = 0;
  int n_err = 0;

  l2_dbg_rptr_arb #(
    .W(W), .NCH(NCH), .STAGES(STAGES), .POST_W(POST_W), .SEL_W(SEL_W)
  ) dut (
    .rclk         (rclk),
    .rst          (rst),
    .dbgbus_in    (dbgbus_in),
    .mode_rr      (mode_rr),
    .trig         (trig),
    .post_cnt     (post_cnt),
    .rearm        (rearm),
    .l2_dbgbus_out(l2_dbgbus_out),
    .enable_out   (enable_out),
    .src_id       (src_id),
    .frozen       (frozen)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  always_comb begin
    dbgbus_in = '0;
    for (int i = 0; i < NCH; i++) dbgbus_in[i*(W+1) +: (W+1)] = {ch_v[i], ch_d[i]};
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic clear_ch();
    ch_v = '0;
    for (int i = 0; i < NCH; i++) ch_d[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    trig = 1'b0;
    rearm = 1'b0;
    clear_ch();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] d, input logic en,
                           input logic [SEL_W-1:0] id);
    check_val({tag, "_data"}, 64'(l2_dbgbus_out), 64'(d));
    check_val({tag, "_en"},   64'(enable_out),    64'(en));
    check_val({tag, "_src"},  64'(src_id),        64'(id));
  endtask

  logic [SEL_W-1:0] rr_all [6];
  logic [SEL_W-1:0] rr_02  [4];

  initial begin
    rr_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rr_02  = '{2'd0, 2'd2, 2'd0, 2'd2};
    rst = 1'b1; mode_rr = 1'b0; trig = 1'b0; rearm = 1'b0; post_cnt = '0;
    clear_ch();
    #1;
    check_out("rst_init", '0, 1'b0, '0);
    check_val("rst_init_frozen", 64'(frozen), 64'd0);
    do_reset();

    // Reset mid-traffic clears outputs before the next edge
    ch_v[0] = 1'b1; ch_d[0] = 40'hAB;
    tick(); tick(); tick();
    check_out("traffic", 40'hAB, 1'b1, 2'd0);
    rst = 1'b1;
    #1;
    check_out("rst_async", '0, 1'b0, '0);
    check_val("rst_async_frozen", 64'(frozen), 64'd0);
    tick();
    rst = 1'b0;
    clear_ch();
    ch_v[2] = 1'b1; ch_d[2] = 40'hCD;
    tick();
    check_val("rst_rel_e1_en", 64'(enable_out), 64'd0);
    tick();
    check_out("rst_rel_e2", 40'hCD, 1'b1, 2'd2);

    // Fixed priority: ch1 beats ch3
    do_reset();
    mode_rr = 1'b0;
    ch_v[1] = 1'b1; ch_d[1] = 40'h11_1111_1111;
    ch_v[3] = 1'b1; ch_d[3] = 40'h33_3333_3333;
    tick(); tick();
    check_out("fixed_pri", 40'h11_1111_1111, 1'b1, 2'd1);
    clear_ch();
    ch_d[2] = 40'hFF_FFFF_FFFF;
    tick(); tick();
    check_out("fixed_none", '0, 1'b0, '0);

    // Round robin, all channels valid
    do_reset();
    mode_rr = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      ch_v[i] = 1'b1;
      ch_d[i] = W'(64'h100 + 64'(i));
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val($sformatf("rr_all_src%0d", k), 64'(src_id), 64'(rr_all[k]));
      check_val($sformatf("rr_all_dat%0d", k), 64'(l2_dbgbus_out), 64'h100 + 64'(rr_all[k]));
    end

    // Round robin, only ch0 and ch2 valid
    do_reset();
    mode_rr = 1'b1;
    ch_v[0] = 1'b1; ch_d[0] = 40'h500;
    ch_v[2] = 1'b1; ch_d[2] = 40'h502;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val($sformatf("rr_02_src%0d", k), 64'(src_id), 64'(rr_02[k]));
    end

    // Trigger with post_cnt=3 at edge 10, stray trig at 12 ignored
    do_reset();
    mode_rr = 1'b0;
    ch_v[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      ch_d[0]  = W'(k);
      trig     = (k == 10 || k == 12);
      post_cnt = (k == 10) ? POST_W'(3) : POST_W'(7);
      tick();
      if (k == 12) check_val("trig3_frozen_e12", 64'(frozen), 64'd0);
      if (k == 13) begin
        check_val("trig3_frozen_e13", 64'(frozen), 64'd1);
        check_val("trig3_out_e13", 64'(l2_dbgbus_out), 64'd12);
      end
      if (k == 14 || k == 18) begin
        check_out($sformatf("trig3_hold_e%0d", k), W'(13), 1'b1, 2'd0);
        check_val($sformatf("trig3_frz_e%0d", k), 64'(frozen), 64'd1);
      end
    end
    trig = 1'b0;
    // Reset while frozen
    rst = 1'b1;
    #1;
    check_out("rst_frozen", '0, 1'b0, '0);
    check_val("rst_frozen_flag", 64'(frozen), 64'd0);
    tick();
    rst = 1'b0;

    // post_cnt=0: freeze on trig edge 5, rearm at edge 20
    do_reset();
    ch_v[0] = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      ch_d[0]  = W'(k);
      trig     = (k == 5);
      post_cnt = '0;
      rearm    = (k == 20);
      tick();
      if (k == 4)  check_val("pc0_frozen_e4", 64'(frozen), 64'd0);
      if (k == 5)  check_val("pc0_frozen_e5", 64'(frozen), 64'd1);
      if (k == 6)  check_val("pc0_out_e6",  64'(l2_dbgbus_out), 64'd5);
      if (k == 19) check_val("pc0_out_e19", 64'(l2_dbgbus_out), 64'd5);
      if (k == 20) begin
        check_val("pc0_frozen_e20", 64'(frozen), 64'd0);
        check_val("pc0_out_e20", 64'(l2_dbgbus_out), 64'd5);
      end
      if (k == 21) check_val("pc0_out_e21", 64'(l2_dbgbus_out), 64'd20);
      if (k == 22) check_val("pc0_out_e22", 64'(l2_dbgbus_out), 64'd21);
    end
    trig = 1'b0; rearm = 1'b0;

    // trig and rearm on the same edge: stays ARMED
    do_reset();
    ch_v[0] = 1'b1;
    tick(); tick();
    trig = 1'b1; rearm = 1'b1; post_cnt = POST_W'(2);
    tick();
    check_val("trig_rearm_e0", 64'(frozen), 64'd0);
    trig = 1'b0; rearm = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ch_d[0] = W'(64'h700 + 64'(k));
      tick();
    end
    check_val("trig_rearm_later", 64'(frozen), 64'd0);
    check_val("trig_rearm_flow", 64'(l2_dbgbus_out), 64'h703);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
